// File: rtl/stump_result_stage.sv
// Stump result stage: register bank, PC and condition codes
// updated from the ALU, plus operand reads and branch evaluation.
module stump_result_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [3:0]               alu_flags,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic                     cc_en,
  input  logic                     pc_inc,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_a,
  output logic [WIDTH-1:0]         rd_data_b,
  output logic [WIDTH-1:0]         pc_out,
  output logic [3:0]               cc_out,
  input  logic [3:0]               cond,
  output logic                     cond_true
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [WIDTH-1:0] gpr [1:NREGS-2];
  logic [WIDTH-1:0] pc;
  logic [3:0]       cc;

  // general registers R1..R(n-2); R0 and PC live elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NREGS - 2; i++)
        gpr[i] <= '0;
    end else begin
      for (int i = 1; i <= NREGS - 2; i++)
        if (wr_en && wr_addr == i[AW-1:0])
          gpr[i] <= alu_result;
    end
  end

  // PC: explicit write beats fetch increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (wr_en && wr_addr == PC_A)
      pc <= alu_result;
    else if (pc_inc)
      pc <= pc + 1'b1;
  end

  // condition codes {N,Z,V,C}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc <= '0;
    else if (cc_en)
      cc <= alu_flags;
  end

  function automatic logic [WIDTH-1:0] rd(
    input logic [AW-1:0] a
  );
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 1; i <= NREGS - 2; i++)
      if (a == i[AW-1:0])
        d = gpr[i];
    if (a == PC_A)
      d = pc;
    return d;
  endfunction

  // operand reads, no write bypass
  always_comb begin
    rd_data_a = rd(rd_addr_a);
    rd_data_b = rd(rd_addr_b);
  end

  assign pc_out = pc;
  assign cc_out = cc;

  // branch condition from stored CC only
  always_comb begin
    logic n, z, v, c;
    {n, z, v, c} = cc;
    cond_true = 1'b0;
    unique case (cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = !c && !z;
      4'h3: cond_true = c || z;
      4'h4: cond_true = !c;
      4'h5: cond_true = c;
      4'h6: cond_true = !z;
      4'h7: cond_true = z;
      4'h8: cond_true = !v;
      4'h9: cond_true = v;
      4'hA: cond_true = !n;
      4'hB: cond_true = n;
      4'hC: cond_true = n == v;
      4'hD: cond_true = n != v;
      4'hE: cond_true = !z && (n == v);
      4'hF: cond_true = z || (n != v);
    endcase
  end

endmodule

// File: tb/tb_stump_result_stage.sv
// Directed bench for stump_result_stage.
// Checks reset, reads/writes, PC priority, CC and conditions.
module tb_stump_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic        cc_en;
  logic        pc_inc;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [15:0] pc_out;
  logic [3:0]  cc_out;
  logic [3:0]  cond;
  logic        cond_true;

  int total = 0;
  int bad = 0;

  stump_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .cc_en(cc_en), .pc_inc(pc_inc),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pc_out(pc_out), .cc_out(cc_out),
    .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; cc_en = 0; pc_inc = 0;
  endtask

  task automatic set_cc(input logic [3:0] f);
    cc_en = 1; alu_flags = f;
    step();
    cc_en = 0;
  endtask

  function automatic logic ref_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, v, cf;
    {n, z, v, cf} = f;
    case (c)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return ~cf & ~z;
      4'h3: return cf | z;
      4'h4: return ~cf;
      4'h5: return cf;
      4'h6: return ~z;
      4'h7: return z;
      4'h8: return ~v;
      4'h9: return v;
      4'hA: return ~n;
      4'hB: return n;
      4'hC: return ~(n ^ v);
      4'hD: return n ^ v;
      4'hE: return ~z & ~(n ^ v);
      default: return z | (n ^ v);
    endcase
  endfunction

  // protocol: flags must be known when captured
  always @(posedge clk)
    if (rst_n === 1'b1 && cc_en === 1'b1 && $isunknown(alu_flags))
      chk("xflags", 16'd1, 16'd0);

  initial begin
    rst_n = 1; idle();
    alu_result = 0; alu_flags = 0;
    wr_addr = 0; rd_addr_a = 0; rd_addr_b = 0; cond = 0;

    // async reset between edges
    #2 rst_n = 0;
    #1;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_cc", {12'h0, cc_out}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      chk("rst_rda", rd_data_a, 16'h0000);
      chk("rst_rdb", rd_data_b, 16'h0000);
    end
    step();
    rst_n = 1;

    // write R3, old value visible before the edge
    wr_en = 1; wr_addr = 3; alu_result = 16'hA5A5;
    rd_addr_a = 3;
    #1 chk("rd_before", rd_data_a, 16'h0000);
    step(); idle();
    chk("rd_after", rd_data_a, 16'hA5A5);

    // R0 write ignored
    wr_en = 1; wr_addr = 0; alu_result = 16'h1234;
    step(); idle();
    rd_addr_a = 0; rd_addr_b = 3;
    #1;
    chk("r0", rd_data_a, 16'h0000);
    chk("r3_keep", rd_data_b, 16'hA5A5);

    // PC load, wrap, priority
    wr_en = 1; wr_addr = 7; alu_result = 16'hFFFF;
    step(); idle();
    rd_addr_b = 7;
    #1;
    chk("pc_load", pc_out, 16'hFFFF);
    chk("rd_r7", rd_data_b, 16'hFFFF);
    pc_inc = 1;
    step(); idle();
    chk("pc_wrap", pc_out, 16'h0000);
    wr_en = 1; wr_addr = 7; alu_result = 16'h0040; pc_inc = 1;
    step(); idle();
    chk("pc_prio", pc_out, 16'h0040);
    pc_inc = 1;
    step(); idle();
    chk("pc_inc", pc_out, 16'h0041);

    // CC gating
    cc_en = 0; alu_flags = 4'b1111;
    step();
    chk("cc_hold", {12'h0, cc_out}, 16'h0000);
    cc_en = 1; alu_flags = 4'b0110;
    step(); idle();
    chk("cc_load", {12'h0, cc_out}, 16'h0006);

    // same-cycle update: branch sees old CC (Z=1)
    cc_en = 1; alu_flags = 4'b1000; cond = 4'h7;
    #1 chk("old_cc_eq", {15'h0, cond_true}, 16'h0001);
    step(); idle();
    chk("cc_1000", {12'h0, cc_out}, 16'h0008);

    // CC = 1000
    cond = 4'hD; #1 chk("lt", {15'h0, cond_true}, 16'h1);
    cond = 4'hC; #1 chk("ge", {15'h0, cond_true}, 16'h0);
    cond = 4'hE; #1 chk("gt", {15'h0, cond_true}, 16'h0);
    cond = 4'hF; #1 chk("le", {15'h0, cond_true}, 16'h1);
    cond = 4'hB; #1 chk("mi", {15'h0, cond_true}, 16'h1);
    cond = 4'h6; #1 chk("ne", {15'h0, cond_true}, 16'h1);

    // CC = 0101
    set_cc(4'b0101);
    cond = 4'h7; #1 chk("eq", {15'h0, cond_true}, 16'h1);
    cond = 4'h2; #1 chk("hi", {15'h0, cond_true}, 16'h0);
    cond = 4'h3; #1 chk("ls", {15'h0, cond_true}, 16'h1);
    cond = 4'h5; #1 chk("cs", {15'h0, cond_true}, 16'h1);

    // full sweep
    for (int f = 0; f < 16; f++) begin
      set_cc(4'(f));
      for (int k = 0; k < 16; k++) begin
        cond = 4'(k);
        #1;
        chk($sformatf("sw_c%0h_f%0h", k, f),
            {15'h0, cond_true},
            {15'h0, ref_cond(4'(k), 4'(f))});
      end
    end

    // reset mid-operation discards pending writes
    wr_en = 1; wr_addr = 4; alu_result = 16'hBEEF;
    step(); idle();
    set_cc(4'b1010);
    rd_addr_a = 4;
    #1 chk("pre_r4", rd_data_a, 16'hBEEF);
    wr_en = 1; wr_addr = 4; alu_result = 16'h1111;
    cc_en = 1; alu_flags = 4'b1111;
    #2 rst_n = 0;
    #1;
    chk("mid_r4", rd_data_a, 16'h0000);
    chk("mid_cc", {12'h0, cc_out}, 16'h0000);
    chk("mid_pc", pc_out, 16'h0000);
    step();
    chk("held_r4", rd_data_a, 16'h0000);
    idle();
    rst_n = 1;
    wr_en = 1; wr_addr = 2; alu_result = 16'h0007;
    rd_addr_b = 2;
    step(); idle();
    chk("post_r2", rd_data_b, 16'h0007);
    chk("post_cc", {12'h0, cc_out}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stump_result_stage.md
Name: stump_result_stage

Overview:
- Sits directly downstream of the Stump ALU.
- Holds the architectural state that the ALU output updates:
  - the 8 x 16-bit register bank, with R0 fixed at zero and R7 as the PC;
  - the 4-bit condition-code (CC) register {N,Z,V,C}.
- Provides the two operand read ports that feed the shifter and ALU.
- Provides the branch-condition evaluation from the stored CC.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 8, register count (address width = 3); R0 zero, R(NREGS-1) is PC.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- alu_result  input  16  ALU result, written to the register bank on write.
- alu_flags  input  4  ALU flags {N,Z,V,C}.
- wr_en  input  1  register write enable from control.
- wr_addr  input  3  destination register.
- cc_en  input  1  CC update enable (instruction S bit AND execute phase).
- pc_inc  input  1  increment PC (fetch phase).
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- rd_data_a  output  16  register A contents (combinational read).
- rd_data_b  output  16  register B contents (combinational read).
- pc_out  output  16  current R7.
- cc_out  output  4  current CC register {N,Z,V,C}.
- cond  input  4  branch condition field.
- cond_true  output  1  condition satisfied by cc_out (combinational).

Behaviour:
- Reset (rst_n low, asynchronous):
  - R1..R7 = 0x0000 and CC = 4'b0000 immediately, independent of clk.
  - Outputs follow: pc_out = 0x0000, cc_out = 0, and rd_data reads 0.
  - Reset asserted mid-operation discards any pending write.
- Release: the first rising edge after rst_n goes high performs normal updates.
- Reads:
  - rd_data_a and rd_data_b are purely combinational from current state; there is no write bypass. A read in the same cycle as a write returns the old value, and the new value is visible after the edge.
  - Reading R0 always returns 0x0000.
  - Reading R7 returns the PC.
- Writes (rising edge):
  - If wr_en, reg[wr_addr] <= alu_result.
  - A write to R0 is ignored.
- PC update (rising edge, priority high to low):
  1. wr_en with wr_addr = 7: PC <= alu_result (branch or explicit write). pc_inc is ignored that cycle.
  2. pc_inc: PC <= PC + 1, modulo 2^16, so 0xFFFF wraps to 0x0000.
  3. Otherwise PC holds.
- CC update (rising edge):
  - If cc_en, CC <= alu_flags; otherwise CC holds.
  - cc_en and wr_en are independent and may be asserted together.
  - Control never asserts cc_en for ALU func 110/111 (flags undefined). If alu_flags carries X while cc_en = 1, that is a bench-checked protocol violation.
- cond_true, with N,Z,V,C taken from cc_out:
  - 0 AL: 1.
  - 1 NV: 0.
  - 2 HI: !C & !Z.
  - 3 LS: C | Z.
  - 4 CC: !C.
  - 5 CS: C.
  - 6 NE: !Z.
  - 7 EQ: Z.
  - 8 VC: !V.
  - 9 VS: V.
  - A PL: !N.
  - B MI: N.
  - C GE: N == V.
  - D LT: N != V.
  - E GT: !Z & (N == V).
  - F LE: Z | (N != V).
- Evaluation always uses the stored CC, never the in-flight alu_flags. A CC update and a branch test in the same cycle therefore see the old CC.
- No multi-driver or latch inference: the register array has one write port and the PC is a dedicated register.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 between clock edges.
  - Response: pc_out = 0x0000 and cc_out = 0 within the same delta, without any clk edge.
  - Stimulus: read all 8 addresses.
  - Response: every read returns 0x0000.
- Write/read and R0:
  - Stimulus: wr_en, wr_addr = 3, alu_result = 0xA5A5, with rd_addr_a = 3 in the same cycle.
  - Response: 0x0000 that cycle, 0xA5A5 after the edge.
  - Stimulus: write 0x1234 to R0.
  - Response: R0 still reads 0x0000.
- PC wrap and priority:
  - Stimulus: load PC = 0xFFFF, then pc_inc.
  - Response: pc_out = 0x0000.
  - Stimulus: wr_en, wr_addr = 7, alu_result = 0x0040, with pc_inc = 1.
  - Response: pc_out = 0x0040, not 0x0001.
- CC gating:
  - Stimulus: cc_en = 0, alu_flags = 4'b1111.
  - Response: cc_out unchanged at 0.
  - Stimulus: cc_en = 1, alu_flags = 4'b0110.
  - Response: cc_out = 4'b0110 after the edge.
- Conditions:
  - Stimulus: CC = 4'b1000 (N = 1, V = 0).
  - Response: LT = 1, GE = 0, GT = 0, LE = 1, MI = 1, NE = 1.
  - Stimulus: CC = 4'b0101 (Z = 1, C = 1).
  - Response: EQ = 1, HI = 0, LS = 1, CS = 1.
  - Sweep all 16 codes over all 16 CC values and compare against a reference model.
- Reset mid-operation:
  - Stimulus: pulse rst_n low while wr_en = 1 and cc_en = 1 are pending.
  - Response: the written register and CC are cleared to 0.
  - Stimulus: release reset, then a write of 0x0007 to R2.
  - Response: R2 reads 0x0007 after the first edge.
